// File: rtl/uz_foc_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined unsigned x signed multiplier
// between several FOC requesters. The winning operands are registered into
// the multiplier, and a tag pipeline running alongside the multiplier routes
// each product back to the requester that issued it.
module uz_foc_mul_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int MUL_LATENCY = 4,
  parameter int A_WIDTH     = 6,
  parameter int B_WIDTH     = 25,
  parameter int P_WIDTH     = 25
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]         res_valid,
  output logic [P_WIDTH-1:0]         res_p,
  output logic                       mul_ce,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic                       busy
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // The issue register accounts for one cycle of latency; the tag stages
  // cover the multiplier's own pipeline depth.
  localparam int STAGES = MUL_LATENCY - 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [ID_W-1:0]    last_grant_r;
  logic               issue_valid_r;
  logic [ID_W-1:0]    issue_id_r;
  logic [A_WIDTH-1:0] din0_r;
  logic [B_WIDTH-1:0] din1_r;
  logic               tag_valid_r [STAGES];
  logic [ID_W-1:0]    tag_id_r    [STAGES];

  logic               found_s;
  logic [ID_W-1:0]    grant_id_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               handshake_s;
  logic [A_WIDTH-1:0] a_sel_s;
  logic [B_WIDTH-1:0] b_sel_s;
  logic               tag_busy_s;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int idx;
    found_s    = 1'b0;
    grant_id_s = last_grant_r;
    idx        = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant_r) + off) % NUM_REQ;
      if (!found_s && req_valid[idx[ID_W-1:0]]) begin
        found_s    = 1'b1;
        grant_id_s = idx[ID_W-1:0];
      end else begin
        found_s    = found_s;
      end
    end
    if (found_s) begin
      grant_s = ONE_HOT0 << grant_id_s;
    end else begin
      grant_s = '0;
    end
  end

  // Select the operands of the granted requester.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        a_sel_s = req_a[i*A_WIDTH +: A_WIDTH];
        b_sel_s = req_b[i*B_WIDTH +: B_WIDTH];
      end else begin
        a_sel_s = a_sel_s;
      end
    end
  end

  assign handshake_s = ce & found_s;
  assign req_ready   = ce ? grant_s : '0;

  // Remember the last winner so the next search starts just after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= ID_W'(NUM_REQ - 1);
    end else if (handshake_s) begin
      last_grant_r <= grant_id_s;
    end
  end

  // Issue register: launches the accepted operands into the multiplier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid_r <= 1'b0;
      issue_id_r    <= '0;
      din0_r        <= '0;
      din1_r        <= '0;
    end else if (ce) begin
      issue_valid_r <= handshake_s;
      if (handshake_s) begin
        issue_id_r <= grant_id_s;
        din0_r     <= a_sel_s;
        din1_r     <= b_sel_s;
      end
    end
  end

  // Tag pipeline tracking which requester owns each product in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        tag_valid_r[s] <= 1'b0;
        tag_id_r[s]    <= '0;
      end
    end else if (ce) begin
      tag_valid_r[0] <= issue_valid_r;
      tag_id_r[0]    <= issue_id_r;
      for (int s = 1; s < STAGES; s++) begin
        tag_valid_r[s] <= tag_valid_r[s-1];
        tag_id_r[s]    <= tag_id_r[s-1];
      end
    end
  end

  // Any tag still travelling alongside the multiplier keeps busy high.
  always_comb begin
    tag_busy_s = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      tag_busy_s = tag_busy_s | tag_valid_r[s];
    end
  end

  // Result strobe follows the last tag stage and is suppressed while frozen.
  always_comb begin
    if (ce && tag_valid_r[STAGES-1]) begin
      res_valid = ONE_HOT0 << tag_id_r[STAGES-1];
    end else begin
      res_valid = '0;
    end
  end

  assign res_p    = mul_dout;
  assign mul_ce   = ce;
  assign mul_din0 = din0_r;
  assign mul_din1 = din1_r;
  assign busy     = issue_valid_r | tag_busy_s;

endmodule

// File: tb/tb_uz_foc_mul_arbiter.sv
// Directed bench for uz_foc_mul_arbiter with a 3-stage external multiplier.
`timescale 1ns/1ps
module tb_uz_foc_mul_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [17:0] req_a;
  logic [74:0] req_b;
  logic [2:0]  res_valid;
  logic [24:0] res_p;
  logic        mul_ce;
  logic [5:0]  mul_din0;
  logic [24:0] mul_din1;
  logic [24:0] mul_dout;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  uz_foc_mul_arbiter dut (
    .clk(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_p(res_p),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // External multiplier: 3 register stages, enabled by mul_ce, never reset.
  logic [24:0] mp0 = 25'd0;
  logic [24:0] mp1 = 25'd0;
  logic [24:0] mp2 = 25'd0;
  logic signed [31:0] full_s;
  assign full_s = $signed({26'd0, mul_din0}) * $signed({{7{mul_din1[24]}}, mul_din1});
  always @(posedge clk) begin
    if (mul_ce) begin
      mp0 <= full_s[24:0];
      mp1 <= mp0;
      mp2 <= mp1;
    end
  end
  assign mul_dout = mp2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [5:0] a, input logic [24:0] b);
    req_a[i*6 +: 6]   = a;
    req_b[i*25 +: 25] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'b1; req_valid = 3'b000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Fixed operands for the multi-requester tests.
  task automatic load_table();
    set_op(0, 6'd1, 25'd100);          // 100       -> 0000064
    set_op(1, 6'd2, -25'sd7);          // -14       -> 1FFFFF2
    set_op(2, 6'd5, 25'd9);            // 45        -> 000002D
  endtask

  logic [24:0] prod_tab [3];
  logic [2:0]  exp_v;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    prod_tab[0] = 25'h0000064;
    prod_tab[1] = 25'h1FFFFF2;
    prod_tab[2] = 25'h000002D;
    req_a = 18'd0; req_b = 75'd0;
    reset = 1'b1; ce = 1'b1; req_valid = 3'b000;
    #1;
    @(negedge clk);
    check("rst_ready", {29'd0, req_ready}, 32'd0);
    check("rst_res_valid", {29'd0, res_valid}, 32'd0);
    check("rst_din0", {26'd0, mul_din0}, 32'd0);
    check("rst_din1", {7'd0, mul_din1}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mul_ce", {31'd0, mul_ce}, 32'd1);
    do_reset();

    // Single product: req0 a=3 b=-5 -> 1FFFFF1 at T+4.
    set_op(0, 6'd3, -25'sd5);
    req_valid = 3'b001;
    @(negedge clk);
    check("single_ready", {29'd0, req_ready}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      req_valid = 3'b000;
      @(negedge clk);
      check($sformatf("single_busy_c%0d", k), {31'd0, busy}, (k <= 4) ? 32'd1 : 32'd0);
      check($sformatf("single_res_c%0d", k), {29'd0, res_valid}, (k == 4) ? 32'd1 : 32'd0);
      if (k == 1) check("single_din0", {26'd0, mul_din0}, 32'd3);
      if (k == 4) check("single_res_p", {7'd0, res_p}, 32'h1FFFFF1);
    end

    // Fairness under full load.
    do_reset();
    load_table();
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 6) ? 3'b111 : 3'b000;
      @(negedge clk);
      check($sformatf("fair_ready_c%0d", k), {29'd0, req_ready},
            (k < 6) ? (32'd1 << (k % 3)) : 32'd0);
      exp_v = (k >= 4) ? (3'b001 << ((k - 4) % 3)) : 3'b000;
      check($sformatf("fair_res_c%0d", k), {29'd0, res_valid}, {29'd0, exp_v});
      if (k >= 4) check($sformatf("fair_p_c%0d", k), {7'd0, res_p}, {7'd0, prod_tab[(k - 4) % 3]});
      tick();
    end

    // Stall mid-flight: ce=0 for cycles 3 and 4 delays results to 6,7,8.
    do_reset();
    load_table();
    for (int k = 0; k < 11; k++) begin
      ce = (k == 3 || k == 4) ? 1'b0 : 1'b1;
      req_valid = (k < 5) ? 3'b111 : 3'b000;
      @(negedge clk);
      check($sformatf("stall_ready_c%0d", k), {29'd0, req_ready},
            (k < 3) ? (32'd1 << k) : 32'd0);
      exp_v = (k >= 6 && k <= 8) ? (3'b001 << (k - 6)) : 3'b000;
      check($sformatf("stall_res_c%0d", k), {29'd0, res_valid}, {29'd0, exp_v});
      if (k >= 6 && k <= 8) check($sformatf("stall_p_c%0d", k), {7'd0, res_p}, {7'd0, prod_tab[k - 6]});
      tick();
    end
    ce = 1'b1;

    // Reset mid-flight: three in flight, reset in cycle 3.
    do_reset();
    load_table();
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 3 || k == 9) ? 3'b111 : 3'b000;
      reset = (k == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (k >= 3) begin
        check($sformatf("rstmid_busy_c%0d", k), {31'd0, busy}, 32'd0);
        check($sformatf("rstmid_res_c%0d", k), {29'd0, res_valid}, 32'd0);
      end
      if (k == 9) check("rstmid_first_grant", {29'd0, req_ready}, 32'd1);
      tick();
    end
    req_valid = 3'b000;

    // Truncation corners, back-to-back from a single requester.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) set_op(0, 6'd63, 25'h1000000);
      else        set_op(0, 6'd0, 25'h0FFFFFF);
      req_valid = (k < 2) ? 3'b001 : 3'b000;
      @(negedge clk);
      check($sformatf("trunc_ready_c%0d", k), {29'd0, req_ready}, (k < 2) ? 32'd1 : 32'd0);
      check($sformatf("trunc_res_c%0d", k), {29'd0, res_valid}, (k == 4 || k == 5) ? 32'd1 : 32'd0);
      if (k == 4) check("trunc_p_neg", {7'd0, res_p}, 32'h1000000);
      if (k == 5) check("trunc_p_zero", {7'd0, res_p}, 32'd0);
      tick();
    end

    // Withdrawal: req1 drops after cycle 0; grants 0,2,0,2.
    do_reset();
    load_table();
    for (int k = 0; k < 9; k++) begin
      if (k == 0)     req_valid = 3'b111;
      else if (k < 4) req_valid = 3'b101;
      else            req_valid = 3'b000;
      @(negedge clk);
      check($sformatf("wd_ready_c%0d", k), {29'd0, req_ready},
            (k < 4) ? ((k % 2 == 0) ? 32'd1 : 32'd4) : 32'd0);
      exp_v = (k >= 4 && k <= 7) ? ((k % 2 == 0) ? 3'b001 : 3'b100) : 3'b000;
      check($sformatf("wd_res_c%0d", k), {29'd0, res_valid}, {29'd0, exp_v});
      if (k >= 4 && k <= 7)
        check($sformatf("wd_p_c%0d", k), {7'd0, res_p}, {7'd0, (k % 2 == 0) ? prod_tab[0] : prod_tab[2]});
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
